// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, main FSM
// states, and the ALUOp / ALU source B / PC source select codes.
package mips_ctrl_pkg;

    // instr[31:26] opcodes handled by the main control FSM
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Main FSM state encoding
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // ALUOp, consumed by the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU source B select
    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcodes that go through the address-calculation state
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath. Moore state machine with
// memory handshake gating in FETCH / MEMRD / MEMWR; outputs are decoded from
// the state register and forced inactive while reset_n is low.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mem_op(opcode))      state_d = S_MEMADR;
                else if (opcode == OP_RTYPE) state_d = S_EXECUTE;
                else if (opcode == OP_BEQ)   state_d = S_BRANCH;
                else if (opcode == OP_ADDI)  state_d = S_ADDIEX;
                else if (opcode == OP_J)     state_d = S_JUMP;
                else                         state_d = S_FETCH;
            end
            S_MEMADR: begin
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH,
            S_ADDIWB,
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode; reset forces strobes low and selects to FETCH values
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_B;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH;
                if (!(is_mem_op(opcode) || opcode == OP_RTYPE || opcode == OP_BEQ ||
                      opcode == OP_ADDI || opcode == OP_J)) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                mem_req = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                pc_src     = PCSRC_ALUOUT;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // Reset overrides the state decode so no write escapes in the reset cycle
        if (!reset_n) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = ALUB_FOUR;
            alu_op     = ALUOP_ADD;
            pc_src     = PCSRC_ALU;
            pc_write   = 1'b0;
            branch     = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end

        pc_en = pc_write | (branch & zero);
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm. Each cycle the full
// output bundle is compared against a hand-written per-state vector.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, pc_en, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle order: mem_req iord mem_write ir_write reg_dst mem_to_reg reg_write
    //               alu_src_a alu_src_b[2] alu_op[2] pc_src[2] pc_en instr_done illegal_op
    logic [16:0] outv;
    assign outv = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, illegal_op};

    localparam logic [16:0] V_RESET     = 17'b0_0_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [16:0] V_FETCH_RDY = 17'b1_0_0_1_0_0_0_0_01_00_00_1_0_0;
    localparam logic [16:0] V_FETCH_WT  = 17'b1_0_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [16:0] V_DECODE    = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [16:0] V_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_11_00_00_0_1_1;
    localparam logic [16:0] V_MEMADR    = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [16:0] V_MEMRD     = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] V_MEMWB     = 17'b0_0_0_0_0_1_1_0_00_00_00_0_1_0;
    localparam logic [16:0] V_MEMWR_WT  = 17'b1_1_1_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] V_MEMWR_RDY = 17'b1_1_1_0_0_0_0_0_00_00_00_0_1_0;
    localparam logic [16:0] V_EXECUTE   = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [16:0] V_ALUWB     = 17'b0_0_0_0_1_0_1_0_00_00_00_0_1_0;
    localparam logic [16:0] V_BR_TAKEN  = 17'b0_0_0_0_0_0_0_1_00_01_01_1_1_0;
    localparam logic [16:0] V_BR_NOT    = 17'b0_0_0_0_0_0_0_1_00_01_01_0_1_0;
    localparam logic [16:0] V_ADDIEX    = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [16:0] V_ADDIWB    = 17'b0_0_0_0_0_0_1_0_00_00_00_0_1_0;
    localparam logic [16:0] V_JUMP      = 17'b0_0_0_0_0_0_0_0_00_00_10_1_1_0;

    // Compare the settled outputs for this cycle, then advance to just after the next edge
    task automatic step(input logic [16:0] exp, input string tag);
        #1;
        checks++;
        assert (outv === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, outv, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(V_RESET, "reset_initial");
        reset_n = 1'b1;

        // R-type: 4 cycles, back-to-back FETCH in cycle 5
        opcode = 6'b000000;
        step(V_FETCH_RDY, "rtype_fetch");
        step(V_DECODE,    "rtype_decode");
        step(V_EXECUTE,   "rtype_execute");
        step(V_ALUWB,     "rtype_aluwb");

        // lw with FETCH wait and 3 MEMRD wait cycles: 9 cycles total here
        opcode = 6'b100011;
        mem_ready = 1'b0;
        step(V_FETCH_WT,  "lw_fetch_wait");
        mem_ready = 1'b1;
        step(V_FETCH_RDY, "lw_fetch");
        mem_ready = 1'b0;          // ignored in DECODE/MEMADR
        step(V_DECODE,    "lw_decode");
        step(V_MEMADR,    "lw_memadr");
        step(V_MEMRD,     "lw_memrd_wait1");
        step(V_MEMRD,     "lw_memrd_wait2");
        step(V_MEMRD,     "lw_memrd_wait3");
        mem_ready = 1'b1;
        step(V_MEMRD,     "lw_memrd_ready");
        step(V_MEMWB,     "lw_memwb");

        // beq taken: zero high throughout, DECODE must not raise pc_en
        opcode = 6'b000100;
        zero = 1'b1;
        step(V_FETCH_RDY, "beq_t_fetch");
        step(V_DECODE,    "beq_t_decode");
        step(V_BR_TAKEN,  "beq_t_branch");

        // beq not taken
        zero = 1'b0;
        step(V_FETCH_RDY, "beq_n_fetch");
        step(V_DECODE,    "beq_n_decode");
        step(V_BR_NOT,    "beq_n_branch");

        // Illegal opcode: single pulse in DECODE, then FETCH
        opcode = 6'b111111;
        step(V_FETCH_RDY, "ill_fetch");
        step(V_DEC_ILL,   "ill_decode");

        // Opcode 000001 is also unsupported
        opcode = 6'b000001;
        step(V_FETCH_RDY, "ill2_fetch");
        step(V_DEC_ILL,   "ill2_decode");

        // addi
        opcode = 6'b001000;
        step(V_FETCH_RDY, "addi_fetch");
        step(V_DECODE,    "addi_decode");
        step(V_ADDIEX,    "addi_ex");
        step(V_ADDIWB,    "addi_wb");

        // j then sw back-to-back, sw waits 2 cycles in MEMWR
        opcode = 6'b000010;
        step(V_FETCH_RDY, "j_fetch");
        step(V_DECODE,    "j_decode");
        step(V_JUMP,      "j_jump");
        opcode = 6'b101011;
        step(V_FETCH_RDY, "sw_fetch");
        step(V_DECODE,    "sw_decode");
        step(V_MEMADR,    "sw_memadr");
        mem_ready = 1'b0;
        step(V_MEMWR_WT,  "sw_memwr_wait1");
        step(V_MEMWR_WT,  "sw_memwr_wait2");
        mem_ready = 1'b1;
        step(V_MEMWR_RDY, "sw_memwr_ready");

        // Second sw, reset for 2 cycles while in MEMWR with mem_ready high
        step(V_FETCH_RDY, "sw2_fetch");
        step(V_DECODE,    "sw2_decode");
        step(V_MEMADR,    "sw2_memadr");
        zero = 1'b1;
        reset_n = 1'b0;
        step(V_RESET,     "reset_memwr_1");
        step(V_RESET,     "reset_memwr_2");
        reset_n = 1'b1;
        zero = 1'b0;
        opcode = 6'b000000;
        step(V_FETCH_RDY, "post_reset_fetch");
        step(V_DECODE,    "post_reset_decode");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath mux select and write strobe, plus the 2-bit ALUOp consumed by the existing ALU decoder. Sits beside the ALU decoder in the control unit, with a ready/request handshake to the unified instruction/data memory.

## Interface
- No parameters; encodings are fixed by the shared package.
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access active (read, or write when mem_write=1).
- iord  out  1  address mux: 0=PC, 1=ALUOut.
- mem_write  out  1  write enable qualifying mem_req.
- ir_write  out  1  load instruction register.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=Data register.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2.
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded.
- pc_src  out  2  00=ALUResult, 01=ALUOut, 10=jump target.
- pc_en  out  1  pc_write | (branch & zero).
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- Moore FSM. All outputs not listed for a state are 0.
- FETCH: mem_req=1, alu_src_b=01.
  - If mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise hold in FETCH with strobes 0.
- DECODE: alu_src_b=11, which computes the branch target.
  - lw/sw go to MEMADR.
  - R-type goes to EXECUTE.
  - beq goes to BRANCH.
  - addi goes to ADDIEX.
  - j goes to JUMP.
  - Any other opcode: illegal_op=1, instr_done=1, go to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: iord=1, mem_req=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1, go to FETCH.
- MEMWR: iord=1, mem_req=1, mem_write=1. Hold until mem_ready; on that cycle instr_done=1 and go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10, go to ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1, go to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, branch=1, pc_src=01, instr_done=1, go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, go to ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1, instr_done=1, go to FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1, go to FETCH.
- Gating: pc_write and ir_write in FETCH are qualified by mem_ready. mem_write is a level held for the whole MEMWR dwell.

## Timing
- Reset: on a clk edge with reset_n=0, state goes to FETCH.
- While reset_n=0, the following are forced to 0 combinationally:
  - write strobes: ir_write, pc_write, pc_en, reg_write, mem_write
  - mem_req, instr_done, illegal_op
- Mux selects show FETCH values during reset: alu_src_b=01, all others 0.
- Reset mid-instruction abandons it with no write issued in the reset cycle. The next cycle after reset_n rises is FETCH.
- Latency with zero-wait memory (mem_ready held 1):
  - lw 5 cycles
  - sw 4, R-type 4, addi 4
  - beq 3, j 3
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored outside those three states.
- opcode is sampled only in DECODE and MEMADR; it must be stable from ir_write until instr_done.
- pc_en is combinational from state and zero in the same cycle.
- The back-to-back FETCH after instr_done has no bubble.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the 4-bit state encoding (FETCH=0 … JUMP=11)
  - ALUOp, alu_src_b and pc_src encodings
- The ALU decoder consumes the ALUOp encoding from the same package.
- Single module: a state register plus next-state and output decode.
- No sub-module needed; the ALU decoder is instantiated alongside this block at control-unit level, not inside it.

## Test plan
- Reset: reset_n=0 for 2 cycles while in MEMWR with mem_ready=1 -> mem_write=0, reg_write=0, pc_en=0; first cycle after release is FETCH with mem_req=1.
- R-type (opcode 000000), mem_ready=1 -> FETCH, DECODE, EXECUTE (alu_op=10), ALUWB (reg_write=1, reg_dst=1); instr_done in cycle 4; next FETCH in cycle 5.
- lw with mem_ready low 3 cycles in MEMRD -> 8 cycles total; reg_write=1 and mem_to_reg=1 only in MEMWB; mem_req=1 through the MEMRD wait.
- beq, zero=1 then zero=0 -> BRANCH pc_en=1 with pc_src=01 in the first case; pc_en=0 in the second; both complete in 3 cycles.
- Illegal opcode 111111 -> illegal_op and instr_done pulse once in DECODE, then FETCH; no reg_write or mem_write at any point.
- j then sw back-to-back -> JUMP pc_src=10, pc_en=1; sw MEMWR holds mem_write=1, iord=1 until mem_ready; instr_done on the mem_ready cycle.
